// File: rtl/agc_mem_pkg.sv
// Shared types and address constants for the erasable memory sequencer.
// Address classes come from the 12-bit S register and the erasable bank.
package agc_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SENSE,
    HOLD,
    WRITE,
    FIN
  } mem_state_t;

  localparam logic [11:0] CREG_LIMIT = 12'o10;
  localparam logic [11:0] FIXED_BASE = 12'o2000;
  localparam logic [1:0]  BANK_SEL   = 2'b11;

endpackage

// File: rtl/agc_parity16.sv
// 16-bit XOR reduction tree.
// Used for both parity checking and parity generation.
module agc_parity16 (
  input  logic [15:0] d,
  output logic        p
);

  logic [7:0] l1;
  logic [3:0] l2;
  logic [1:0] l3;

  assign l1 = d[15:8] ^ d[7:0];
  assign l2 = l1[7:4] ^ l1[3:0];
  assign l3 = l2[3:2] ^ l2[1:0];
  assign p  = l3[1] ^ l3[0];

endmodule

// File: rtl/erasable_memory_sequencer.sv
// Erasable core memory cycle sequencer.
// Sequences read, sense, write-back hold and write strobes.
module erasable_memory_sequencer
  import agc_mem_pkg::*;
#(
  parameter int RD_CYC = 2,
  parameter int WR_CYC = 2
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        MSTRT,
  input  logic [11:0] S,
  input  logic [2:0]  EB,
  input  logic [15:0] RD,
  input  logic [14:0] WB,
  input  logic        WBGO,
  input  logic        PCHK,
  input  logic        PALCLR,
  output logic [10:0] EAD,
  output logic        RDSTB,
  output logic        SASTB,
  output logic        WRSTB,
  output logic [15:0] WD,
  output logic [15:0] G,
  output logic        BUSY,
  output logic        DONE,
  output logic        REGSEL,
  output logic        FMEM,
  output logic        PALARM
);

  mem_state_t  state;
  logic [2:0]  cnt;
  logic        wb_pend;
  logic        rd_par;
  logic        wb_par;
  logic        is_creg;
  logic        is_fixed;
  logic        pal_set;
  logic [10:0] ead_nx;

  agc_parity16 u_chk (
    .d(RD),
    .p(rd_par)
  );

  agc_parity16 u_gen (
    .d({1'b0, WB}),
    .p(wb_par)
  );

  assign is_creg  = S < CREG_LIMIT;
  assign is_fixed = S >= FIXED_BASE;
  assign ead_nx   = (S[9:8] == BANK_SEL) ? {EB, S[7:0]}
                                         : {1'b0, S[9:8], S[7:0]};
  // Even overall parity on the sensed word is a bad read.
  assign pal_set  = (state == SENSE) && PCHK && !rd_par;

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state   <= IDLE;
      cnt     <= '0;
      wb_pend <= 1'b0;
      EAD     <= '0;
      RDSTB   <= 1'b0;
      SASTB   <= 1'b0;
      WRSTB   <= 1'b0;
      WD      <= '0;
      G       <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      REGSEL  <= 1'b0;
      FMEM    <= 1'b0;
      PALARM  <= 1'b0;
    end else begin
      DONE  <= 1'b0;
      SASTB <= 1'b0;
      if (pal_set)
        PALARM <= 1'b1;
      else if (PALCLR)
        PALARM <= 1'b0;
      unique case (state)
        IDLE: begin
          if (MSTRT) begin
            EAD    <= ead_nx;
            REGSEL <= is_creg;
            FMEM   <= is_fixed;
            BUSY   <= 1'b1;
            if (!is_creg && !is_fixed) begin
              state <= READ;
              RDSTB <= 1'b1;
              cnt   <= 3'(RD_CYC - 1);
            end else begin
              state <= FIN;
              DONE  <= 1'b1;
            end
          end
        end
        READ: begin
          if (cnt == 3'd0) begin
            RDSTB <= 1'b0;
            SASTB <= 1'b1;
            state <= SENSE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        SENSE: begin
          G       <= RD;
          wb_pend <= WBGO;
          state   <= HOLD;
        end
        HOLD: begin
          if (WBGO || wb_pend) begin
            WD      <= {~wb_par, WB};
            WRSTB   <= 1'b1;
            cnt     <= 3'(WR_CYC - 1);
            wb_pend <= 1'b0;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (cnt == 3'd0) begin
            WRSTB <= 1'b0;
            DONE  <= 1'b1;
            state <= FIN;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        FIN: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/erasable_memory_sequencer.md
ERASABLE_MEMORY_SEQUENCER -- requirements
Module: erasable_memory_sequencer

Interface
REQ-001 Parameter RD_CYC, default 2: number of clocks RDSTB is held high per read phase; legal range 1..7.
REQ-002 Parameter WR_CYC, default 2: number of clocks WRSTB is held high per write phase; legal range 1..7.
REQ-003 Port SIM_CLK, input, 1: the single clock; all state changes occur on its rising edge.
REQ-004 Port SIM_RST, input, 1: reset, synchronous, active-high.
REQ-005 Port MSTRT, input, 1: one-clock memory-cycle start pulse.
REQ-006 Port S, input, 12: S-register address S12..S01; sampled only on an accepted MSTRT.
REQ-007 Port EB, input, 3: erasable bank; sampled with S.
REQ-008 Port RD, input, 16: sense-amp readout; bit 16 is parity.
REQ-009 Port WB, input, 15: write-back data.
REQ-010 Port WBGO, input, 1: write-back release.
REQ-011 Port PCHK, input, 1: parity-check enable.
REQ-012 Port PALCLR, input, 1: clears PALARM.
REQ-013 Port EAD, output, 11: erasable core address.
REQ-014 Port RDSTB, output, 1: read strobe.
REQ-015 Port SASTB, output, 1: sense strobe.
REQ-016 Port WRSTB, output, 1: write strobe.
REQ-017 Port WD, output, 16: write data including generated parity.
REQ-018 Port G, output, 16: G register.
REQ-019 Port BUSY, output, 1: high while a cycle is in progress.
REQ-020 Port DONE, output, 1: one-clock end-of-cycle pulse.
REQ-021 Port REGSEL, output, 1: central-register address flag.
REQ-022 Port FMEM, output, 1: fixed-memory address flag.
REQ-023 Port PALARM, output, 1: sticky parity alarm.

Function
REQ-024 Address classes: S<8 (octal 0-7) -> central register; S[12:11]!=0 -> fixed; otherwise erasable.
REQ-025 EAD SHALL be {EB,S[8:1]} when S[10:9]=2'b11, else {1'b0,S[10:9],S[8:1]}, latched on an accepted MSTRT and held until the next accepted MSTRT.
REQ-026 FSM states: IDLE, READ, SENSE, HOLD, WRITE, FIN.
REQ-027 IDLE + MSTRT, erasable -> READ; RDSTB=1 for exactly RD_CYC clocks, then -> SENSE.
REQ-028 SENSE lasts 1 clock with SASTB=1; at the end of SENSE, G<=RD.
REQ-029 Parity check at the end of SENSE: when PCHK=1 and the XOR of RD[16:1] is 0 (even, i.e. bad), PALARM SHALL set the next clock.
REQ-030 HOLD waits for WBGO=1 (WBGO in the same clock as SENSE end is honoured in the first HOLD clock), then -> WRITE.
REQ-031 WRITE: WD latched at HOLD exit as {~^WB, WB} (odd parity over 16 bits); WRSTB=1 for exactly WR_CYC clocks; then -> FIN.
REQ-032 FIN: DONE=1 for 1 clock -> IDLE.
REQ-033 IDLE + MSTRT, non-erasable: REGSEL or FMEM set, no strobes, -> FIN; the flags hold until the next accepted MSTRT.
REQ-034 BUSY=1 in every state except IDLE; MSTRT while BUSY SHALL be ignored.
REQ-035 RDSTB, SASTB and WRSTB SHALL be mutually exclusive in every clock.
REQ-036 PALARM stays set until PALCLR; PALCLR in the same clock as a new set event -> set wins.

Reset
REQ-037 SIM_RST=1 forces IDLE at the next edge, even mid-cycle; all strobes, BUSY, DONE, REGSEL, FMEM and PALARM go to 0, and EAD, G and WD go to 0.
REQ-038 No DONE SHALL be emitted for a cycle aborted by reset.

Structure
REQ-039 The FSM state enum, the address-class constants (octal 10, 2000) and the bank select code 2'b11 SHALL live in a shared package agc_mem_pkg.
REQ-040 One sub-module, agc_parity16 (16-bit XOR tree), SHALL be instantiated twice: once for the check and once for generation.

Verification
REQ-041 S=0o1400, EB=5, MSTRT -> EAD=0o2400; RDSTB high 2 clocks; SASTB high 1 clock; BUSY high through FIN.
REQ-042 RD=16'h0001, PCHK=1 -> PALARM=0; RD=16'h0003 -> PALARM=1, held until PALCLR.
REQ-043 WB=15'h0000 with WBGO after 3 HOLD clocks -> WD=16'h8000; WRSTB high 2 clocks; DONE pulse 1 clock.
REQ-044 S=0o0005 -> REGSEL=1, no strobes, DONE one clock after MSTRT; S=0o4000 -> FMEM=1.
REQ-045 Reset asserted in the second WRITE clock -> IDLE next clock; WRSTB=0; DONE never asserted.
REQ-046 MSTRT pulsed during READ with new S -> ignored; EAD unchanged.
